memoria_principal_resp: RTL and testbench

Main-memory responder at the memory side of the cache/memory interface. It accepts block requests from the 2-way set-associative cache controller: an optional write-back of a dirty victim, then an optional fill read. It holds the word store and models a fixed access latency. It completes each request with a one-cycle ack that carries the fill data.

---
 rtl/memoria_pkg.sv | 15 +
 rtl/memoria_array.sv | 32 +++
 rtl/memoria_principal_resp.sv | 135 +++++++++++++
 tb/tb_memoria_principal_resp.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// Shared definitions for the cache/memory interface: responder FSM states and
// the default word/address widths used by both the cache controller and memory.
package memoria_pkg;

    localparam int unsigned MEM_DATA_W = 3;
    localparam int unsigned MEM_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WB_WAIT,
        RD_WAIT,
        RESP
    } mem_state_e;

endpackage

// File: rtl/memoria_array.sv
// Main-memory word store: synchronous write, combinational read,
// synchronous clear of every word on reset.
module memoria_array #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memoria_principal_resp.sv
// Memory-side responder: optional victim write-back then optional fill read,
// each phase taking LATENCY cycles, completed by a one-cycle ack.
module memoria_principal_resp
    import memoria_pkg::*;
#(
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              req_wb,
    input  logic              req_fill,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] fill_data
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "memoria_principal_resp: LATENCY must be in 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_e        r_state, w_next_state;
    logic [3:0]        r_cnt, w_cnt_next;
    logic              r_busy, r_ack;
    logic [DATA_W-1:0] r_fill_data;

    logic              r_wb, r_fill;
    logic [ADDR_W-1:0] r_wb_addr, r_fill_addr;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_capture, w_we, w_load_fill;
    logic [DATA_W-1:0] w_rdata;

    memoria_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_we   (w_we),
        .i_waddr(r_wb_addr),
        .i_wdata(r_wb_data),
        .i_raddr(r_fill_addr),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_we         = 1'b0;
        w_load_fill  = 1'b0;
        case (r_state)
            IDLE: begin
                // Routing uses the live request bits since they are captured on this same edge
                if (req) begin
                    w_capture  = 1'b1;
                    w_cnt_next = CNT_LOAD;
                    if (req_wb)        w_next_state = WB_WAIT;
                    else if (req_fill) w_next_state = RD_WAIT;
                    else               w_next_state = RESP;
                end
            end
            WB_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_we = 1'b1;
                    if (r_fill) begin
                        w_next_state = RD_WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end else begin
                        w_next_state = RESP;
                    end
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RD_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_load_fill  = 1'b1;
                    w_next_state = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_fill_data <= '0;
            r_wb        <= 1'b0;
            r_fill      <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_fill_addr <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_busy  <= (w_next_state != IDLE);
            r_ack   <= (w_next_state == RESP);
            if (w_capture) begin
                r_wb        <= req_wb;
                r_fill      <= req_fill;
                r_wb_addr   <= wb_addr;
                r_wb_data   <= wb_data;
                r_fill_addr <= fill_addr;
            end
            if (w_load_fill) begin
                r_fill_data <= w_rdata;
            end
        end
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign fill_data = r_fill_data;

endmodule

// File: tb/tb_memoria_principal_resp.sv
// Randomised self-checking bench for memoria_principal_resp against a
// request-level memory model (word array plus expected ack latency).
module tb_memoria_principal_resp;

    localparam int unsigned DW  = 3;
    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          req, req_wb, req_fill;
    logic [AW-1:0] wb_addr, fill_addr;
    logic [DW-1:0] wb_data;
    logic          busy, ack;
    logic [DW-1:0] fill_data;

    memoria_principal_resp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_wb   (req_wb),
        .req_fill (req_fill),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .fill_addr(fill_addr),
        .busy     (busy),
        .ack      (ack),
        .fill_data(fill_data)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] model_mem [2**AW];
    logic [DW-1:0] model_fill;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
        model_fill = '0;
    endtask

    // One complete transaction; inputs are scrambled once captured to prove they are ignored.
    // With hold=1, req stays high past the ack so the next call's request is accepted back-to-back.
    task automatic issue(input bit wb, input bit fill, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] fa, input bit hold);
        int lat;
        lat = 1 + (wb ? LAT : 0) + (fill ? LAT : 0);
        @(negedge clock);
        req = 1'b1; req_wb = wb; req_fill = fill;
        wb_addr = wa; wb_data = wd; fill_addr = fa;
        if (wb)   model_mem[wa] = wd;
        if (fill) model_fill = model_mem[fa];
        @(posedge clock);
        #1;
        req_wb    = 1'($urandom);
        req_fill  = 1'($urandom);
        wb_addr   = AW'($urandom);
        wb_data   = DW'($urandom);
        fill_addr = AW'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clock);
                #1;
            end
            check("busy_in_flight", busy, 1'b1);
            check("ack_timing", ack, (k == lat) ? 1'b1 : 1'b0);
            if (k == lat) check("fill_data_at_ack", fill_data, model_fill);
        end
        if (!hold) req = 1'b0;
        @(posedge clock);
        #1;
        check("busy_after_ack", busy, 1'b0);
        check("ack_after_ack", ack, 1'b0);
    endtask

    // Write-back request interrupted by reset before the write commits.
    task automatic abort_wb(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clock);
        req = 1'b1; req_wb = 1'b1; req_fill = 1'b0; wb_addr = wa; wb_data = wd;
        @(posedge clock);
        #1;
        check("abort_busy_pre", busy, 1'b1);
        req = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
        check("abort_busy", busy, 1'b0);
        check("abort_ack", ack, 1'b0);
        check("abort_fill_data", fill_data, model_fill);
        reset = 1'b0;
    endtask

    initial begin
        bit wb, fl, hold;
        logic [AW-1:0] wa, fa;
        logic [DW-1:0] wd;
        reset = 1'b1; req = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
        wb_addr = '0; wb_data = '0; fill_addr = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_ack", ack, 1'b0);
        check("reset_fill_data", fill_data, 3'b000);
        reset = 1'b0;

        issue(1'b0, 1'b1, 5'h00, 3'b000, 5'h0A, 1'b0);
        issue(1'b1, 1'b0, 5'h13, 3'b101, 5'h00, 1'b0);
        issue(1'b0, 1'b1, 5'h00, 3'b000, 5'h13, 1'b0);
        issue(1'b1, 1'b1, 5'h07, 3'b110, 5'h07, 1'b0);
        issue(1'b1, 1'b0, 5'h03, 3'b100, 5'h00, 1'b0);
        issue(1'b1, 1'b1, 5'h1F, 3'b011, 5'h03, 1'b0);
        issue(1'b0, 1'b1, 5'h00, 3'b000, 5'h1F, 1'b0);
        issue(1'b0, 1'b1, 5'h00, 3'b000, 5'h13, 1'b1);
        issue(1'b1, 1'b0, 5'h0A, 3'b010, 5'h00, 1'b0);
        issue(1'b0, 1'b0, 5'h11, 3'b111, 5'h11, 1'b0);
        abort_wb(5'h15, 3'b111);
        issue(1'b0, 1'b1, 5'h00, 3'b000, 5'h15, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                abort_wb(AW'($urandom), DW'($urandom));
            end else begin
                wb   = 1'($urandom);
                fl   = 1'($urandom);
                wa   = AW'($urandom);
                wd   = DW'($urandom);
                fa   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
                hold = (i < 149) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
                issue(wb, fl, wa, wd, fa, hold);
            end
        end
        for (int a = 0; a < 2**AW; a += 7) begin
            issue(1'b0, 1'b1, 5'h00, 3'b000, AW'(a), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
